// File: rtl/lsu_dmem.sv
`default_nettype none
// ============================================================================
// Module   : lsu_dmem
// Purpose  : RV32I load/store unit. It takes the ALU result as the effective
//            address and runs one access on a req/gnt/rvalid data-memory port.
//            The core is stalled until the access completes. Load data is
//            sign- or zero-extended. Misaligned accesses, illegal funct3
//            values and timed-out accesses end with err.
// Ports    : clk, rst_n             clock, async active-low reset
//            mem_read, mem_write   access request (a store wins if both)
//            funct3, addr, wdata   access size/sign, address, store data
//            stall, done, err      pipeline hold, completion pulse, error
//            load_data             extended load result (valid while done)
//            dmem_*                data-memory request/response port
// Revision : 1.0 - initial release
// ============================================================================
module lsu_dmem #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic [31:0] load_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_WAIT = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    localparam int              c_CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CW-1:0] c_TMAX  = c_CW'(TIMEOUT - 1);
    localparam bit              c_TO_EN = (TIMEOUT != 0);

    logic [1:0]      r_state;
    logic [1:0]      w_next;
    logic [31:0]     r_addr;
    logic [2:0]      r_funct3;
    logic [31:0]     r_wdata;
    logic            r_we;
    logic [c_CW-1:0] r_cnt;
    logic [31:0]     r_load_data;
    logic            r_err;

    logic            w_start;
    logic            w_legal;
    logic            w_misaligned;
    logic            w_bad;
    logic            w_tmo;
    logic            w_err_next;
    logic            w_busy;
    logic [3:0]      w_be;
    logic [31:0]     w_wlane;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [31:0]     w_ext;

    assign w_start = mem_read | mem_write;
    assign w_busy  = (r_state == c_REQ) || (r_state == c_WAIT);
    assign w_tmo   = c_TO_EN && (r_cnt == c_TMAX);

    // Legality is judged on the live inputs, so an IDLE-cycle decision never
    // needs the latched copies. Unsigned loads have no store counterpart.
    always_comb begin
        w_legal = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b010: w_legal = 1'b1;
            3'b100, 3'b101:         w_legal = ~mem_write;
            default:                w_legal = 1'b0;
        endcase
    end

    assign w_misaligned = ((funct3[1:0] == 2'b01) & addr[0]) |
                          ((funct3[1:0] == 2'b10) & (|addr[1:0]));
    assign w_bad        = ~w_legal | w_misaligned;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next     = r_state;
        w_err_next = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_start) begin
                    if (w_bad) begin
                        w_next     = c_DONE;
                        w_err_next = 1'b1;
                    end else begin
                        w_next = c_REQ;
                    end
                end
            end
            c_REQ: begin
                // A grant in the last allowed cycle still counts.
                if (dmem_gnt) begin
                    w_next = r_we ? c_DONE : c_WAIT;
                end else if (w_tmo) begin
                    w_next     = c_DONE;
                    w_err_next = 1'b1;
                end
            end
            c_WAIT: begin
                if (dmem_rvalid) begin
                    w_next = c_DONE;
                end else if (w_tmo) begin
                    w_next     = c_DONE;
                    w_err_next = 1'b1;
                end
            end
            default: w_next = c_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // stall is gated by rst_n so that reset forces it low immediately, even
    // while the core still presents a load or store.
    always_comb begin
        stall      = rst_n & (w_busy | ((r_state == c_IDLE) & w_start));
        done       = (r_state == c_DONE);
        dmem_req   = (r_state == c_REQ);
        dmem_we    = (r_state == c_REQ) & r_we;
        dmem_be    = (r_state == c_REQ) ? w_be : 4'b0000;
        dmem_addr  = (r_state == c_REQ) ? {r_addr[31:2], 2'b00} : 32'h0;
        dmem_wdata = ((r_state == c_REQ) & r_we) ? w_wlane : 32'h0;
    end

    assign err       = r_err;
    assign load_data = r_load_data;

    // Byte enables and lane-replicated store data come from the latched access.
    always_comb begin
        w_be    = 4'b1111;
        w_wlane = r_wdata;
        case (r_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << r_addr[1:0];
                w_wlane = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << r_addr[1:0];
                w_wlane = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wlane = r_wdata;
            end
        endcase
    end

    // Load lane select and extension.
    always_comb begin
        w_byte = dmem_rdata[7:0];
        case (r_addr[1:0])
            2'b00:   w_byte = dmem_rdata[7:0];
            2'b01:   w_byte = dmem_rdata[15:8];
            2'b10:   w_byte = dmem_rdata[23:16];
            default: w_byte = dmem_rdata[31:24];
        endcase
        w_half = r_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_ext = {24'h0, w_byte};
            3'b101:  w_ext = {16'h0, w_half};
            default: w_ext = dmem_rdata;
        endcase
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= 32'h0;
            r_funct3    <= 3'b000;
            r_wdata     <= 32'h0;
            r_we        <= 1'b0;
            r_cnt       <= '0;
            r_load_data <= 32'h0;
            r_err       <= 1'b0;
        end else begin
            if ((r_state == c_IDLE) && w_start) begin
                r_addr   <= addr;
                r_funct3 <= funct3;
                r_wdata  <= wdata;
                r_we     <= mem_write;
            end
            // The counter restarts on every state change, so REQ and WAIT
            // each get their own full budget.
            if (w_busy && (w_next == r_state)) begin
                r_cnt <= r_cnt + c_CW'(1);
            end else begin
                r_cnt <= '0;
            end
            // load_data and err are non-zero only during the DONE cycle.
            r_load_data <= ((r_state == c_WAIT) && dmem_rvalid) ? w_ext : 32'h0;
            r_err       <= w_err_next;
        end
    end

endmodule
`default_nettype wire

// File: doc/lsu_dmem.md
Name: lsu_dmem

Overview:
- Load/store unit directly downstream of the execute ALU in the RV32I core.
- Takes the ALU Result as the effective address, plus rs2 store data and funct3 from decode.
- Drives a req/gnt/rvalid data-memory port and stalls the core until the access completes.
- Sign- or zero-extends load data for writeback and flags misaligned, illegal or timed-out accesses.

Parameters:
- TIMEOUT, 16: max cycles spent in REQ or WAIT before the access is aborted with err; 0 disables the timeout.

Ports:
- clk  input  1  core clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- mem_read  input  1  current instruction is a load
- mem_write  input  1  current instruction is a store; has priority if both are high
- funct3  input  3  access size and sign (RV32I load/store encoding)
- addr  input  32  effective address from the ALU Result
- wdata  input  32  store data (rs2)
- stall  output  1  hold PC and pipeline registers
- done  output  1  one-cycle pulse when the access completes
- err  output  1  one-cycle pulse together with done: misaligned, illegal funct3 or timeout
- load_data  output  32  extended load result; valid while done=1
- dmem_req  output  1  memory request
- dmem_we  output  1  write enable
- dmem_addr  output  32  word-aligned address, {addr[31:2],2'b00}
- dmem_be  output  4  byte enables
- dmem_wdata  output  32  lane-replicated store data
- dmem_gnt  input  1  request accepted
- dmem_rvalid  input  1  read data valid, earliest one cycle after gnt
- dmem_rdata  input  32  read data word

Behaviour:
- Reset values: every output 0; state IDLE; timeout counter 0. Reset asserted mid-access drops dmem_req to 0 immediately and discards the access.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, start = mem_read|mem_write:
  - When start=1, stall is driven high combinationally.
  - Latch addr, funct3, wdata and the we bit (we = mem_write).
  - Legal and aligned: go to REQ.
  - Otherwise: go to DONE with err set, issuing no memory request.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000, 001, 010 only.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]≠0.
- REQ:
  - dmem_req=1; dmem_addr, dmem_be, dmem_wdata and dmem_we held stable until gnt.
  - On gnt: a store goes to DONE; a load goes to WAIT.
- WAIT: dmem_req=0. On rvalid, capture the extended data into load_data and go to DONE.
- Timeout: the counter increments in REQ and WAIT and clears on any state change. When TIMEOUT≠0 and count = TIMEOUT-1 without the awaited gnt or rvalid, go to DONE with err set and load_data=0.
- DONE: done=1, stall=0, always go to IDLE. load_data and err are held for this cycle only, then cleared to 0.
- stall = (state∈{REQ,WAIT}) | (state==IDLE & start).
- Store lanes:
  - SB: be = 4'b0001<<addr[1:0]; wdata = {4{wdata[7:0]}}.
  - SH: be = 4'b0011<<addr[1:0]; wdata = {2{wdata[15:0]}}.
  - SW: be = 4'b1111; wdata = wdata.
- Load lanes:
  - Byte: select rdata[8*addr[1:0]+:8].
  - Half: select rdata[16*addr[1]+:16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Minimum latency with gnt in the first REQ cycle:
  - Store: 3 cycles, IDLE→REQ→DONE.
  - Load with rvalid one cycle after gnt: 4 cycles.
- dmem_be = 0 and dmem_we = 0 whenever dmem_req = 0.

Test Plan:
- SB: addr=0x1003, wdata=0x000000A5, gnt immediate -> dmem_addr=0x1000, be=4'b1000, dmem_wdata=0xA5A5A5A5, done on 3rd cycle, err=0.
- LB then LBU: addr=0x2002, rdata=0x12F0_3456, rvalid one cycle after gnt -> load_data=0xFFFFFFF0, then 0x000000F0; stall high exactly 3 cycles.
- LH: addr=0x3001 -> no dmem_req; err=1 and done=1 on cycle 2; load_data=0.
- LW: addr=0x4000, gnt withheld 5 cycles, rdata=0xDEADBEEF -> dmem_req held with stable dmem_addr throughout; load_data=0xDEADBEEF.
- TIMEOUT=4, LW, gnt never asserted -> dmem_req high exactly 4 cycles, then done=1, err=1, stall drops.
- rst_n asserted low while in WAIT -> dmem_req=0, stall=0, all outputs 0 asynchronously; next LW completes normally.
